// File: rtl/led_rgb_pwm.sv
// RGB LED output stage: period-aligned colour/duty latch, PWM dimming
// and an optional blink FSM stepped once per PWM period.
module led_rgb_pwm #(
    parameter int PWM_W      = 8,
    parameter int BLINK_HALF = 195312
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       color_in,
    input  logic [PWM_W-1:0] duty,
    input  logic             blink_en,
    output logic [2:0]       rgb_pwm,
    output logic             period_tick
);

    localparam int BW = $clog2(BLINK_HALF + 1);
    localparam logic [PWM_W-1:0] CNT_MAX = {PWM_W{1'b1}};
    localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_HALF - 1);

    typedef enum logic {
        BLINK_ON  = 1'b0,
        BLINK_OFF = 1'b1
    } blink_e;

    logic [PWM_W-1:0] cnt_q, cnt_d;
    logic [2:0]       col_q, col_d;
    logic [PWM_W-1:0] duty_q, duty_d;
    logic             ben_q, ben_d;
    blink_e           state_q, state_d;
    logic [BW-1:0]    bcnt_q, bcnt_d;
    logic [2:0]       rgb_q, rgb_d;
    logic             tick_q, tick_d;
    logic             boundary;
    logic             pwm_on;

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            col_q   <= '0;
            duty_q  <= '0;
            ben_q   <= 1'b0;
            state_q <= BLINK_ON;
            bcnt_q  <= '0;
            rgb_q   <= '0;
            tick_q  <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            col_q   <= col_d;
            duty_q  <= duty_d;
            ben_q   <= ben_d;
            state_q <= state_d;
            bcnt_q  <= bcnt_d;
            rgb_q   <= rgb_d;
            tick_q  <= tick_d;
        end
    end

    always_comb begin
        cnt_d    = cnt_q + 1'b1;
        col_d    = col_q;
        duty_d   = duty_q;
        ben_d    = ben_q;
        state_d  = state_q;
        bcnt_d   = bcnt_q;
        boundary = (cnt_q == CNT_MAX);
        tick_d   = boundary;
        // Mask uses the currently latched settings; new ones apply from count 0
        pwm_on = (state_q == BLINK_ON) &&
                 ((duty_q == CNT_MAX) || (cnt_q < duty_q));
        rgb_d = col_q & {3{pwm_on}};
        if (boundary) begin
            col_d  = color_in;
            duty_d = duty;
            ben_d  = blink_en;
            if (!blink_en || !ben_q) begin
                state_d = BLINK_ON;
                bcnt_d  = '0;
            end else if (bcnt_q == BLINK_LAST) begin
                bcnt_d = '0;
                case (state_q)
                    BLINK_ON:  state_d = BLINK_OFF;
                    BLINK_OFF: state_d = BLINK_ON;
                    default:   state_d = BLINK_ON;
                endcase
            end else begin
                bcnt_d = bcnt_q + 1'b1;
            end
        end
    end

    assign rgb_pwm     = rgb_q;
    assign period_tick = tick_q;

endmodule

// File: tb/tb_led_rgb_pwm.sv
// Directed bench for led_rgb_pwm with PWM_W=4 (period 16) and BLINK_HALF=2.
// Each period is checked cycle by cycle against hand-chosen colour/high-count.
module tb_led_rgb_pwm;

    logic       clk;
    logic       reset;
    logic [2:0] color_in;
    logic [3:0] duty;
    logic       blink_en;
    logic [2:0] rgb_pwm;
    logic       period_tick;

    int total;
    int bad;

    led_rgb_pwm #(
        .PWM_W      (4),
        .BLINK_HALF (2)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .color_in    (color_in),
        .duty        (duty),
        .blink_en    (blink_en),
        .rgb_pwm     (rgb_pwm),
        .period_tick (period_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [2:0] obs,
                         input logic [2:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    // One full period starting with count 0: 'hi' cycles of 'col', then off.
    // Optionally changes color_in just before the edge where count==chg_at.
    task automatic run_period(input logic [2:0] col, input int hi,
                              input int chg_at, input logic [2:0] chg_col,
                              input string tag);
        for (int k = 0; k < 16; k++) begin
            if (k == chg_at) color_in = chg_col;
            @(posedge clk);
            #1;
            check($sformatf("%s rgb k=%0d", tag, k), rgb_pwm,
                  (k < hi) ? col : 3'b000);
            check($sformatf("%s tick k=%0d", tag, k), {2'b00, period_tick},
                  {2'b00, (k == 15)});
        end
    endtask

    initial begin
        total    = 0;
        bad      = 0;
        reset    = 1'b1;
        color_in = 3'b000;
        duty     = 4'd0;
        blink_en = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset rgb", rgb_pwm, 3'b000);
        check("reset tick", {2'b00, period_tick}, 3'b000);

        // red at duty 4; the first period still shows the reset state
        color_in = 3'b100;
        duty     = 4'd4;
        run_period(3'b000, 0, -1, 3'b000, "p1");
        run_period(3'b100, 4, -1, 3'b000, "p2");

        // new settings requested mid-stream only take effect next period
        color_in = 3'b111;
        duty     = 4'd0;
        run_period(3'b100, 4, -1, 3'b000, "p3");
        duty = 4'd15;
        run_period(3'b000, 0, -1, 3'b000, "p4_duty0");

        color_in = 3'b100;
        duty     = 4'd8;
        run_period(3'b111, 16, -1, 3'b000, "p5_full");
        run_period(3'b100, 8, 2, 3'b010, "p6_midchg");

        // blink: 010 at full duty, two periods on, two off
        duty     = 4'd15;
        blink_en = 1'b1;
        run_period(3'b010, 8, -1, 3'b000, "p7");
        run_period(3'b010, 16, -1, 3'b000, "p8_on");
        run_period(3'b010, 16, -1, 3'b000, "p9_on");
        run_period(3'b000, 0, -1, 3'b000, "p10_off");
        run_period(3'b000, 0, -1, 3'b000, "p11_off");
        run_period(3'b010, 16, -1, 3'b000, "p12_on");
        run_period(3'b010, 16, -1, 3'b000, "p13_on");

        blink_en = 1'b0;
        run_period(3'b000, 0, -1, 3'b000, "p14_off");
        run_period(3'b010, 16, -1, 3'b000, "p15_steady");
        run_period(3'b010, 16, -1, 3'b000, "p16_steady");

        blink_en = 1'b1;
        run_period(3'b010, 16, -1, 3'b000, "p17_steady");
        run_period(3'b010, 16, -1, 3'b000, "p18_on");
        run_period(3'b010, 16, -1, 3'b000, "p19_on");

        color_in = 3'b100;
        duty     = 4'd8;
        blink_en = 1'b0;
        run_period(3'b000, 0, -1, 3'b000, "p20_off");

        // reset pulse while red is mid-pulse at count 3
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("p21 rgb k=%0d", k), rgb_pwm, 3'b100);
        end
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        check("midreset rgb", rgb_pwm, 3'b000);
        check("midreset tick", {2'b00, period_tick}, 3'b000);
        run_period(3'b000, 0, -1, 3'b000, "p22_after_rst");
        run_period(3'b100, 8, -1, 3'b000, "p23");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
